// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the write-back path.
// The forwarding lookup is built only when WB_FWD_EN is defined.
package regfile_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] X0 = '0;

    typedef struct packed {
        logic                  live;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order buffer of load results with per-entry kill-by-rd.
// WB_FWD_EN adds the per-entry match vector and data view for forwarding.
module wb_entry_fifo #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 push_i,
    input  logic [ADDR_WIDTH-1:0]                push_rd_i,
    input  logic [DATA_WIDTH-1:0]                push_data_i,
    input  logic                                 pop_i,
    input  logic                                 kill_i,
    input  logic [ADDR_WIDTH-1:0]                kill_rd_i,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic                                 head_live_o,
    output logic [ADDR_WIDTH-1:0]                head_rd_o,
    output logic [DATA_WIDTH-1:0]                head_data_o,
    output logic [DEPTH-1:0]                     live_o,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]     rd_o
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_WIDTH-1:0]                q_rd_i,
    output logic [DEPTH-1:0]                     match_o,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_o,
    output logic [PW-1:0]                        head_ptr_o
`endif
);

    logic [PW:0]                         head_q, head_d;
    logic [PW:0]                         tail_q, tail_d;
    logic [DEPTH-1:0]                    live_q, live_d;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0]    rd_q, rd_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    data_q, data_d;
    logic [PW-1:0]                       hidx;
    logic [PW-1:0]                       tidx;

    assign hidx    = head_q[PW-1:0];
    assign tidx    = tail_q[PW-1:0];
    assign empty_o = (head_q == tail_q);
    assign full_o  = (hidx == tidx) && (head_q[PW] != tail_q[PW]);

    assign head_live_o = live_q[hidx];
    assign head_rd_o   = rd_q[hidx];
    assign head_data_o = data_q[hidx];
    assign live_o      = live_q;
    assign rd_o        = rd_q;

`ifdef WB_FWD_EN
    // Per-entry match of the forwarding query against live entries.
    always_comb begin
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = live_q[i] && (rd_q[i] == q_rd_i);
        end
    end

    assign data_o     = data_q;
    assign head_ptr_o = hidx;
`endif

    // Next state: kill matching entries, pop head, push tail.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        live_d = live_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == kill_rd_i) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop_i && !empty_o) begin
            live_d[hidx] = 1'b0;
            head_d       = head_q + (PW+1)'(1);
        end
        if (push_i && !full_o) begin
            live_d[tidx] = 1'b1;
            rd_d[tidx]   = push_rd_i;
            data_d[tidx] = push_data_i;
            tail_d       = tail_q + (PW+1)'(1);
        end
    end

    // State registers; reset empties the buffer and clears every live bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            live_q <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            live_q <= live_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU first, buffered loads drain when idle.
// WB_FWD_EN enables the q_addr_i forwarding lookup; otherwise q_* tie to 0.
module wb_arbiter #(
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]    alu_rd_i,
    input  logic [DATA_WIDTH-1:0]    alu_data_i,
    input  logic                     ld_valid_i,
    output logic                     ld_ready_o,
    input  logic [ADDR_WIDTH-1:0]    ld_rd_i,
    input  logic [DATA_WIDTH-1:0]    ld_data_i,
    output logic                     we_o,
    output logic [ADDR_WIDTH-1:0]    rw_o,
    output logic [DATA_WIDTH-1:0]    wdata_o,
    output logic [2**ADDR_WIDTH-1:0] pending_o,
    output logic                     empty_o,
    input  logic [ADDR_WIDTH-1:0]    q_addr_i,
    output logic                     q_hit_o,
    output logic [DATA_WIDTH-1:0]    q_data_o
);

    import regfile_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RZ = ADDR_WIDTH'(X0);

    logic                                alu_we;
    logic                                pop;
    logic                                push;
    logic                                full;
    logic                                fifo_empty;
    logic                                head_live;
    logic [ADDR_WIDTH-1:0]               head_rd;
    logic [DATA_WIDTH-1:0]               head_data;
    logic [DEPTH-1:0]                    live;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0]    rd;

    assign alu_we = alu_valid_i && (alu_rd_i != RZ);
    assign pop    = !alu_we && !fifo_empty;

    assign ld_ready_o = !full && !rst_i;
    assign push = ld_valid_i && ld_ready_o && (ld_rd_i != RZ)
                  && !(alu_we && (ld_rd_i == alu_rd_i));
    assign empty_o = fifo_empty;

`ifdef WB_FWD_EN
    logic [DEPTH-1:0]                    match;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    data;
    logic [PW-1:0]                       head_ptr;
`endif

    wb_entry_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_rd_i   (ld_rd_i),
        .push_data_i (ld_data_i),
        .pop_i       (pop),
        .kill_i      (alu_we),
        .kill_rd_i   (alu_rd_i),
        .full_o      (full),
        .empty_o     (fifo_empty),
        .head_live_o (head_live),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .live_o      (live),
        .rd_o        (rd)
`ifdef WB_FWD_EN
        ,
        .q_rd_i      (q_addr_i),
        .match_o     (match),
        .data_o      (data),
        .head_ptr_o  (head_ptr)
`endif
    );

    // Write-port mux: ALU wins, otherwise the head drains (dead head writes nothing).
    always_comb begin
        we_o    = 1'b0;
        rw_o    = '0;
        wdata_o = '0;
        unique case (1'b1)
            alu_we: begin
                we_o    = 1'b1;
                rw_o    = alu_rd_i;
                wdata_o = alu_data_i;
            end
            pop: begin
                we_o    = head_live && (head_rd != RZ);
                rw_o    = head_rd;
                wdata_o = head_data;
            end
            default: ;
        endcase
        if (rst_i) begin
            we_o = 1'b0;
        end
    end

    // Scoreboard of registers with a live buffered write.
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                pending_o[rd[i]] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] idx;

    // Forwarding: youngest live entry, overridden by the current ALU write.
    always_comb begin
        q_hit_o  = 1'b0;
        q_data_o = '0;
        idx      = '0;
        if (!rst_i && (q_addr_i != RZ)) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_ptr + PW'(k);
                if (match[idx]) begin
                    q_hit_o  = 1'b1;
                    q_data_o = data[idx];
                end
            end
            if (alu_we && (alu_rd_i == q_addr_i)) begin
                q_hit_o  = 1'b1;
                q_data_o = alu_data_i;
            end
        end
    end
`else
    logic unused_q_addr;

    assign unused_q_addr = ^q_addr_i;
    assign q_hit_o       = 1'b0;
    assign q_data_o      = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write-port scoreboard.
// Forwarding expectations follow WB_FWD_EN.
module tb_wb_arbiter;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_data_i;
    logic        we_o;
    logic [4:0]  rw_o;
    logic [31:0] wdata_o;
    logic [31:0] pending_o;
    logic        empty_o;
    logic [4:0]  q_addr_i;
    logic        q_hit_o;
    logic [31:0] q_data_o;

    wb_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_rd_i     (ld_rd_i),
        .ld_data_i   (ld_data_i),
        .we_o        (we_o),
        .rw_o        (rw_o),
        .wdata_o     (wdata_o),
        .pending_o   (pending_o),
        .empty_o     (empty_o),
        .q_addr_i    (q_addr_i),
        .q_hit_o     (q_hit_o),
        .q_data_o    (q_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expw(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        alu_valid_i = 1'b0;
        alu_rd_i    = '0;
        alu_data_i  = '0;
        ld_valid_i  = 1'b0;
        ld_rd_i     = '0;
        ld_data_i   = '0;
        q_addr_i    = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid_i = 1'b1;
        alu_rd_i    = rd;
        alu_data_i  = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] d);
        ld_valid_i = 1'b1;
        ld_rd_i    = rd;
        ld_data_i  = d;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    // Monitor: every register-file write must match the next expected one.
    always @(negedge clk_i) begin
        wr_t e;
        if (we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got rw=%0d wdata=%0h expected none",
                         rw_o, wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_rd", 64'(rw_o), 64'(e.rd));
                chk("wr_data", 64'(wdata_o), 64'(e.data));
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        idle();
        alu(5'd5, 32'h1234);
        ld(5'd8, 32'h88);
        repeat (2) @(posedge clk_i);
        #1;
        neg();
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_ready", 64'(ld_ready_o), 64'd0);
        chk("rst_pending", 64'(pending_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_qhit", 64'(q_hit_o), 64'd0);
        chk("rst_qdata", 64'(q_data_o), 64'd0);
        idle();
        rst_i = 1'b0;
        #1;
        chk("rel_ready", 64'(ld_ready_o), 64'd1);
        chk("rel_empty", 64'(empty_o), 64'd1);
        tick();

        // ALU write goes straight to the port
        expw(5'd5, 32'hDEADBEEF);
        alu(5'd5, 32'hDEADBEEF);
        tick();
        idle();

        // Load buffered behind a concurrent ALU write
        expw(5'd3, 32'h33);
        expw(5'd7, 32'h11);
        alu(5'd3, 32'h33);
        ld(5'd7, 32'h11);
        neg();
        chk("buf_ready", 64'(ld_ready_o), 64'd1);
        tick();
        idle();
        neg();
        chk("buf_pend7_c1", 64'(pending_o[7]), 64'd1);
        tick();
        neg();
        chk("buf_pend7_c2", 64'(pending_o[7]), 64'd0);
        chk("buf_empty", 64'(empty_o), 64'd1);
        chk("buf_sb", 64'(exp_q.size()), 64'd0);
        tick();

        // Fill the FIFO while the ALU owns the port
        for (int i = 1; i <= 6; i++) expw(5'd20, 32'h100 + i);
        for (int i = 1; i <= 5; i++) expw(5'(i), 32'h1000 + i);
        for (int i = 1; i <= 4; i++) begin
            alu(5'd20, 32'h100 + i);
            ld(5'(i), 32'h1000 + i);
            tick();
        end
        alu(5'd20, 32'h105);
        ld(5'd5, 32'h1005);
        neg();
        chk("full_ready", 64'(ld_ready_o), 64'd0);
        chk("full_pending", 64'(pending_o), 64'h1E);
        tick();
        alu(5'd20, 32'h106);
        neg();
        chk("full_ready2", 64'(ld_ready_o), 64'd0);
        tick();
        alu_valid_i = 1'b0;
        neg();
        chk("full_pop_noearly", 64'(ld_ready_o), 64'd0);
        tick();
        neg();
        chk("full_ready_free", 64'(ld_ready_o), 64'd1);
        tick();
        idle();
        repeat (3) tick();
        neg();
        chk("full_empty", 64'(empty_o), 64'd1);
        chk("full_sb", 64'(exp_q.size()), 64'd0);
        tick();

        // WAW kill of a buffered load
        expw(5'd9, 32'h90);
        ld(5'd9, 32'h99);
        tick();
        idle();
        alu(5'd9, 32'h90);
        neg();
        chk("waw_pend_before", 64'(pending_o), 64'(1) << 9);
        tick();
        idle();
        neg();
        chk("waw_pend_after", 64'(pending_o), 64'd0);
        chk("waw_dead_we", 64'(we_o), 64'd0);
        chk("waw_not_empty", 64'(empty_o), 64'd0);
        tick();
        neg();
        chk("waw_empty", 64'(empty_o), 64'd1);
        tick();

        // Load to the same rd as a concurrent ALU write is discarded
        expw(5'd12, 32'hC0);
        alu(5'd12, 32'hC0);
        ld(5'd12, 32'hC1);
        neg();
        chk("disc_ready", 64'(ld_ready_o), 64'd1);
        tick();
        idle();
        neg();
        chk("disc_empty", 64'(empty_o), 64'd1);
        tick();

        // x0 never buffered nor written
        alu(5'd0, 32'h77);
        ld(5'd0, 32'h55);
        neg();
        chk("x0_we", 64'(we_o), 64'd0);
        chk("x0_ready", 64'(ld_ready_o), 64'd1);
        tick();
        idle();
        neg();
        chk("x0_empty", 64'(empty_o), 64'd1);
        chk("x0_pending", 64'(pending_o), 64'd0);
        tick();

        // Reset while a load waits to drain
        expw(5'd22, 32'h2200);
        alu(5'd22, 32'h2200);
        ld(5'd13, 32'h1300);
        tick();
        idle();
        rst_i = 1'b1;
        #1;
        chk("mrst_we", 64'(we_o), 64'd0);
        chk("mrst_empty", 64'(empty_o), 64'd1);
        chk("mrst_pending", 64'(pending_o), 64'd0);
        chk("mrst_ready", 64'(ld_ready_o), 64'd0);
        neg();
        rst_i = 1'b0;
        tick();
        neg();
        chk("mrst_sb", 64'(exp_q.size()), 64'd0);
        tick();

        // Forwarding lookup
        expw(5'd21, 32'h2101);
        expw(5'd21, 32'h2102);
        expw(5'd21, 32'h2103);
        expw(5'd6, 32'hC);
        alu(5'd21, 32'h2101);
        ld(5'd6, 32'hA);
        tick();
        alu(5'd21, 32'h2102);
        ld(5'd6, 32'hB);
        tick();
        ld_valid_i = 1'b0;
        alu(5'd21, 32'h2103);
        q_addr_i = 5'd6;
        neg();
        chk("fwd_pend6", 64'(pending_o), 64'(1) << 6);
        chk("fwd_fifo_hit", 64'(q_hit_o), 64'(FWD));
        chk("fwd_fifo_data", 64'(q_data_o), FWD ? 64'hB : 64'd0);
        q_addr_i = 5'd0;
        #1;
        chk("fwd_x0_hit", 64'(q_hit_o), 64'd0);
        chk("fwd_x0_data", 64'(q_data_o), 64'd0);
        q_addr_i = 5'd6;
        tick();
        alu(5'd6, 32'hC);
        neg();
        chk("fwd_alu_hit", 64'(q_hit_o), 64'(FWD));
        chk("fwd_alu_data", 64'(q_data_o), FWD ? 64'hC : 64'd0);
        tick();
        idle();
        q_addr_i = 5'd6;
        neg();
        chk("fwd_killed_hit", 64'(q_hit_o), 64'd0);
        chk("fwd_killed_data", 64'(q_data_o), 64'd0);
        tick();
        tick();
        neg();
        chk("fwd_empty", 64'(empty_o), 64'd1);
        tick();

        chk("final_sb", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the register file's single write port (we/rw/wdata). It merges two result producers: ALU results, which write immediately, and load results, which are buffered in a small in-order FIFO and drained on cycles the ALU leaves the port idle. It also exports a pending-write scoreboard for the decode stall logic and, optionally, a forwarding lookup so operands can be read from buffered results before they reach the register file.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width
- DEPTH, 4, load FIFO entries; power of two, ≥2
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- alu_valid_i  in  1  ALU result present this cycle; always accepted
- alu_rd_i  in  ADDR_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU result
- ld_valid_i  in  1  load result offered
- ld_ready_o  out  1  load result accepted when valid && ready
- ld_rd_i  in  ADDR_WIDTH  load destination register
- ld_data_i  in  DATA_WIDTH  load result
- we_o  out  1  register file write enable
- rw_o  out  ADDR_WIDTH  register file write index
- wdata_o  out  DATA_WIDTH  register file write data
- pending_o  out  2**ADDR_WIDTH  bit r set = live buffered write to r; bit 0 always 0
- empty_o  out  1  FIFO holds no entries
- q_addr_i  in  ADDR_WIDTH  forwarding query index
- q_hit_o  out  1  query matches an in-flight write
- q_data_o  out  DATA_WIDTH  youngest matching data; 0 on miss

## Operation
- FIFO entry = {live, rd, data}; head/tail pointers are ADDR = log2(DEPTH) bits plus 1 wrap bit; full = pointers equal except for the wrap bit.
- Program order: every FIFO entry is older than a concurrent ALU result. A load offered in the same cycle as an ALU result is also older than it.
- Port priority: alu_valid_i with alu_rd_i≠0 → we_o=1, rw_o=alu_rd_i, wdata_o=alu_data_i (combinational). No FIFO pop that cycle.
- Drain: ALU idle (or alu_rd_i=0) and FIFO non-empty → pop head; we_o=head.live, rw_o/wdata_o=head fields. A dead head pops with we_o=0.
- Push: ld_valid_i && ld_ready_o && ld_rd_i≠0 → enqueue live entry at tail. If ld_rd_i=0, or ld_rd_i equals the rd of a concurrent ALU write, the load is accepted and discarded.
- WAW kill: an ALU write to r clears live on every FIFO entry with rd=r in the same edge.
- ld_ready_o = !full. A pop in the same cycle does not free the slot early.
- pending_o: OR over live entries of one-hot(rd). Registered view of FIFO contents only.
- x0 is never written: we_o=0 whenever the selected rd is 0.

## Timing
- ALU result → regfile write: 0 cycles. Lands at the next clk_i edge.
- Accepted load → earliest write: 1 cycle after acceptance, provided the ALU is idle and the entry reaches the head.
- Reset (async assert, released on clock): FIFO empty, all live=0, pointers=0. While rst_i=1: we_o=0, ld_ready_o=0, pending_o=0, empty_o=1, q_hit_o=0, q_data_o=0. The first accept can occur on the first edge after release.
- Reset mid-drain discards all buffered entries. No write is issued.
- pending_o updates on the edge after push/pop/kill.

## Configuration
- WB_FWD_EN defined: q_hit_o/q_data_o are active.
  - Priority: the current ALU write (alu_valid_i, alu_rd_i=q_addr_i) first, then the youngest live FIFO entry with rd=q_addr_i.
  - q_addr_i=0 → miss.
- WB_FWD_EN undefined: no lookup logic is built; q_hit_o=0 and q_data_o=0 constantly.

## Structure
- Shared package regfile_pkg: ADDR_WIDTH/DATA_WIDTH defaults, x0 index constant, wb entry struct {live, rd, data}.
- One natural sub-module: wb_entry_fifo. It holds storage, pointers, full/empty, per-entry kill-by-rd and per-entry match vectors.
- Arbitration, scoreboard OR-reduce and forwarding mux stay in wb_arbiter.

## Test plan
- Reset: rst_i=1 → we_o=0, ld_ready_o=0, pending_o=0, empty_o=1. After release → ld_ready_o=1.
- ALU write: alu_valid_i=1, rd=5, data=0xDEADBEEF → same cycle we_o=1, rw_o=5, wdata_o=0xDEADBEEF.
- Buffered load: cycle0 load rd=7, data=0x11 plus ALU rd=3.
  - Cycle1, ALU idle → we_o=1, rw_o=7, wdata_o=0x11.
  - pending_o[7]=1 in cycle1, 0 in cycle2.
- Full: ALU busy, 4 loads rd=1..4 accepted → ld_ready_o=0. 5th load held until ALU idles. Drain order is 1,2,3,4, then the 5th.
- WAW kill: load rd=9 buffered, then ALU rd=9 → pending_o[9]=0 next cycle. The drain cycle gives we_o=0 and empty_o=1 afterward.
- x0 and forwarding (WB_FWD_EN): load rd=0 accepted → empty_o stays 1.
  - Loads rd=6 data 0xA, then rd=6 data 0xB buffered; query 6 → q_hit_o=1, q_data_o=0xB.
  - With ALU rd=6, data 0xC → q_data_o=0xC.
